// File: rtl/ram_bist_seq.sv
// Start-up sequencer for the per-RAM BIST engines: march pass, optional comparator
// self-check passes, sticky fail accumulation and a per-pass timeout.
module ram_bist_seq #(
  parameter int NUM_RAM = 2,
  parameter int IDX_W   = 1,
  parameter int TO_W    = 18,
  parameter int TIMEOUT = 262143
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   check_en,
  input  logic [NUM_RAM-1:0]     bist_done,
  input  logic [4*NUM_RAM-1:0]   bist_fail,
  output logic [NUM_RAM-1:0]     bist_go,
  output logic [NUM_RAM-1:0]     bist_check,
  output logic                   busy,
  output logic                   done,
  output logic [4*NUM_RAM-1:0]   ram_fail,
  output logic [NUM_RAM-1:0]     chk_bad,
  output logic                   timeout,
  output logic [IDX_W-1:0]       cur_ram
);

  typedef enum logic [3:0] {
    S_IDLE, S_GO, S_WAIT_RUN, S_SETTLE, S_CHK0, S_WAIT_CHK0,
    S_CHK1, S_WAIT_CHK1, S_NEXT, S_FIN
  } state_t;

  typedef enum logic [1:0] {P_RUN, P_CHK0, P_CHK1} pass_t;

  state_t          state, state_n;
  pass_t           pass;
  logic            chk_lat;
  logic [TO_W-1:0] to_cnt;
  logic            settle_cnt;
  logic [3:0]      seen0, seen1;
  logic [3:0]      cur_fail;
  logic            cur_done;
  logic            to_hit;
  logic            last_ram;
  logic            in_wait;
  logic            wait_entry;

  // Only the engine under test is listened to; everything else is masked here.
  always_comb begin
    cur_fail = 4'h0;
    cur_done = 1'b0;
    for (int i = 0; i < NUM_RAM; i++) begin
      if (cur_ram == IDX_W'(i)) begin
        cur_fail = bist_fail[4*i +: 4];
        cur_done = bist_done[i];
      end
    end
  end

  assign to_hit   = (to_cnt == TO_W'(TIMEOUT));
  assign last_ram = (cur_ram == IDX_W'(NUM_RAM - 1));
  assign in_wait  = (state == S_WAIT_RUN) || (state == S_WAIT_CHK0) || (state == S_WAIT_CHK1);
  assign wait_entry = (state_n != state) &&
                      ((state_n == S_WAIT_RUN) || (state_n == S_WAIT_CHK0) || (state_n == S_WAIT_CHK1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // A done on the same edge as the timeout wins, so it is tested first.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:      if (start && !timeout) state_n = S_GO;
      S_GO:        state_n = S_WAIT_RUN;
      S_WAIT_RUN, S_WAIT_CHK0, S_WAIT_CHK1: begin
        if (cur_done)    state_n = S_SETTLE;
        else if (to_hit) state_n = S_FIN;
      end
      S_SETTLE: begin
        if (settle_cnt) begin
          if (pass == P_RUN && chk_lat) state_n = S_CHK0;
          else if (pass == P_CHK0)      state_n = S_CHK1;
          else                          state_n = S_NEXT;
        end
      end
      S_CHK0:      state_n = S_WAIT_CHK0;
      S_CHK1:      state_n = S_WAIT_CHK1;
      S_NEXT:      state_n = last_ram ? S_FIN : S_GO;
      S_FIN:       state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bist_go    <= '0;
      bist_check <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_fail   <= '0;
      chk_bad    <= '0;
      timeout    <= 1'b0;
      cur_ram    <= '0;
      pass       <= P_RUN;
      chk_lat    <= 1'b0;
      to_cnt     <= '0;
      settle_cnt <= 1'b0;
      seen0      <= 4'h0;
      seen1      <= 4'h0;
    end else begin
      done       <= 1'b0;
      settle_cnt <= (state == S_SETTLE);
      if (wait_entry)   to_cnt <= '0;
      else if (in_wait) to_cnt <= to_cnt + TO_W'(1);

      // On timeout the engine levels are frozen: dropping bist_check would start a pass.
      if (in_wait && !cur_done && to_hit) begin
        timeout <= 1'b1;
        busy    <= 1'b0;
        done    <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (start && !timeout) begin
            ram_fail <= '0;
            chk_bad  <= '0;
            cur_ram  <= '0;
            chk_lat  <= check_en;
            busy     <= 1'b1;
          end
        end
        S_GO: begin
          pass <= P_RUN;
          for (int i = 0; i < NUM_RAM; i++)
            if (cur_ram == IDX_W'(i)) bist_go[i] <= 1'b1;
        end
        S_WAIT_RUN: begin
          for (int i = 0; i < NUM_RAM; i++) begin
            if (cur_ram == IDX_W'(i)) begin
              ram_fail[4*i +: 4] <= ram_fail[4*i +: 4] | cur_fail;
              if (cur_done) bist_go[i] <= 1'b0;
            end
          end
        end
        S_CHK0: begin
          pass <= P_CHK0;
          for (int i = 0; i < NUM_RAM; i++)
            if (cur_ram == IDX_W'(i)) bist_check[i] <= 1'b1;
        end
        S_WAIT_CHK0: seen0 <= seen0 | cur_fail;
        S_CHK1: begin
          pass <= P_CHK1;
          for (int i = 0; i < NUM_RAM; i++)
            if (cur_ram == IDX_W'(i)) bist_check[i] <= 1'b0;
        end
        S_WAIT_CHK1: begin
          seen1 <= seen1 | cur_fail;
          for (int i = 0; i < NUM_RAM; i++)
            if (cur_ram == IDX_W'(i) && cur_done)
              chk_bad[i] <= (~&seen0) | (~&(seen1 | cur_fail));
        end
        S_NEXT: begin
          seen0 <= 4'h0;
          seen1 <= 4'h0;
          if (last_ram) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            cur_ram <= cur_ram + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_seq.sv
// Directed bench for ram_bist_seq with two behavioural BIST engine models.
module tb_ram_bist_seq;

  logic       clk, reset, start, check_en;
  logic [1:0] bist_done;
  logic [7:0] bist_fail;
  logic [1:0] bist_go, bist_check;
  logic       busy, done;
  logic [7:0] ram_fail;
  logic [1:0] chk_bad;
  logic       timeout;
  logic [0:0] cur_ram;

  ram_bist_seq #(.NUM_RAM(2), .IDX_W(1), .TO_W(18), .TIMEOUT(50)) dut (
    .clk(clk), .reset(reset), .start(start), .check_en(check_en),
    .bist_done(bist_done), .bist_fail(bist_fail),
    .bist_go(bist_go), .bist_check(bist_check), .busy(busy), .done(done),
    .ram_fail(ram_fail), .chk_bad(chk_bad), .timeout(timeout), .cur_ram(cur_ram)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [3:0] march_mask [2];
  logic [3:0] chk0_mask  [2];
  logic [3:0] chk1_mask  [2];
  bit         hang       [2];

  int  kind [2];
  int  cnt  [2];
  logic go_d [2];
  logic chk_d [2];

  int  done_cnt;
  int  last_done_cyc, last_bdone_cyc;
  int  go_rise_cyc [2];
  int  go_order [$];
  int  chk_ev [$];
  logic [1:0] go_p, chk_p;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Engine model: done 20 cycles after each go rise or check edge, optional fail bursts.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bist_done <= '0;
      bist_fail <= '0;
      for (int i = 0; i < 2; i++) begin
        kind[i] = 0; cnt[i] = 0; go_d[i] = 1'b0; chk_d[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bist_done[i] <= 1'b0;
        bist_fail[4*i +: 4] <= 4'h0;
        if (bist_go[i] && !go_d[i]) begin
          kind[i] = 1; cnt[i] = 0;
        end else if (bist_check[i] != chk_d[i]) begin
          kind[i] = bist_check[i] ? 2 : 3; cnt[i] = 0;
        end else if (kind[i] != 0) begin
          cnt[i]++;
          if (cnt[i] == 10)
            bist_fail[4*i +: 4] <= (kind[i] == 1) ? march_mask[i] :
                                   (kind[i] == 2) ? chk0_mask[i] : chk1_mask[i];
          if (cnt[i] == 20 && !hang[i]) begin
            bist_done[i] <= 1'b1;
            kind[i] = 0;
          end
        end
        go_d[i]  = bist_go[i];
        chk_d[i] = bist_check[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bist_go[i] && !go_p[i]) begin
        go_order.push_back(i);
        go_rise_cyc[i] = cyc;
      end
      if (bist_check[i] != chk_p[i]) chk_ev.push_back(i*2 + (bist_check[i] ? 1 : 0));
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (|bist_done) last_bdone_cyc = cyc;
    go_p  = bist_go;
    chk_p = bist_check;
  end

  task automatic set_models(input logic [3:0] m0, input logic [3:0] m1,
                            input logic [3:0] c00, input logic [3:0] c01,
                            input logic [3:0] c10, input logic [3:0] c11);
    march_mask[0] = m0;  march_mask[1] = m1;
    chk0_mask[0]  = c00; chk0_mask[1]  = c01;
    chk1_mask[0]  = c10; chk1_mask[1]  = c11;
    hang[0] = 1'b0; hang[1] = 1'b0;
  endtask

  task automatic pulse_start(input logic ce);
    @(negedge clk);
    done_cnt = 0;
    go_order.delete();
    chk_ev.delete();
    start = 1'b1;
    check_en = ce;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_en = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    ok = (done_cnt != 0);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    check_en = 1'b0;
    set_models(4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    #1;
    total++;
    if ({bist_go, bist_check, busy, done} !== 6'b0)
      $display("[TB] FAIL reset_ctrl: got %b want 000000", {bist_go, bist_check, busy, done});
    else passed++;
    total++;
    if ({ram_fail, chk_bad, timeout, cur_ram} !== 12'h000)
      $display("[TB] FAIL reset_status: got %h want 000", {ram_fail, chk_bad, timeout, cur_ram});
    else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    set_models(4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    pulse_start(1'b0);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || bist_go !== 2'b00)
      $display("[TB] FAIL basic_accept: got busy=%b go=%b want busy=1 go=00", busy, bist_go);
    else passed++;
    @(negedge clk);
    total++;
    if (bist_go !== 2'b01)
      $display("[TB] FAIL basic_go0: got %b want 01", bist_go);
    else passed++;
    wait_done(400, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok || done_cnt != 1)
      $display("[TB] FAIL basic_done_count: got %0d want 1", done_cnt);
    else passed++;
    total++;
    if (go_order.size() != 2 || go_order[0] != 0 || go_order[1] != 1)
      $display("[TB] FAIL basic_go_order: got %0d rises want 2 in order 0,1", go_order.size());
    else passed++;
    total++;
    if (last_done_cyc - last_bdone_cyc != 4)
      $display("[TB] FAIL basic_done_latency: got %0d want 4", last_done_cyc - last_bdone_cyc);
    else passed++;
    total++;
    if ({ram_fail, chk_bad, timeout, busy} !== 12'h000)
      $display("[TB] FAIL basic_status: got %h want 000", {ram_fail, chk_bad, timeout, busy});
    else passed++;
    total++;
    if (cur_ram !== 1'b1 || bist_go !== 2'b00)
      $display("[TB] FAIL basic_end_state: got cur=%b go=%b want cur=1 go=00", cur_ram, bist_go);
    else passed++;
  endtask

  task automatic test_march_fail;
    bit ok;
    set_models(4'h0, 4'b0100, 4'hF, 4'hF, 4'hF, 4'hF);
    pulse_start(1'b0);
    wait_done(400, ok);
    total++;
    if (!ok || ram_fail !== 8'h40)
      $display("[TB] FAIL march_fail_ram1: got %h want 40", ram_fail);
    else passed++;
  endtask

  task automatic test_checks;
    bit ok;
    set_models(4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    pulse_start(1'b1);
    wait_done(800, ok);
    total++;
    if (!ok || chk_ev.size() != 4 || chk_ev[0] != 1 || chk_ev[1] != 0 ||
        chk_ev[2] != 3 || chk_ev[3] != 2)
      $display("[TB] FAIL checks_edges: got %0d edges want 4 (r0 f0 r1 f1)", chk_ev.size());
    else passed++;
    total++;
    if (chk_bad !== 2'b00 || ram_fail !== 8'h00)
      $display("[TB] FAIL checks_clean: got chk_bad=%b ram_fail=%h want 00/00", chk_bad, ram_fail);
    else passed++;
    total++;
    if (last_done_cyc - last_bdone_cyc != 4)
      $display("[TB] FAIL checks_done_latency: got %0d want 4", last_done_cyc - last_bdone_cyc);
    else passed++;
  endtask

  task automatic test_chk_bad;
    bit ok;
    set_models(4'h0, 4'h0, 4'hF, 4'hF, 4'b1011, 4'hF);
    pulse_start(1'b1);
    wait_done(800, ok);
    total++;
    if (!ok || chk_bad !== 2'b01)
      $display("[TB] FAIL chk_bad_ram0: got %b want 01", chk_bad);
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n = 0;
    set_models(4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    pulse_start(1'b1);
    while (chk_ev.size() == 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (chk_ev.size() == 0)
      $display("[TB] FAIL reset_mid_reach_chk0: got no check edge want rise");
    else passed++;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bist_go, bist_check, busy, done, ram_fail, chk_bad, timeout, cur_ram} !== 18'h0)
      $display("[TB] FAIL reset_mid_outputs: got %h want 0",
               {bist_go, bist_check, busy, done, ram_fail, chk_bad, timeout, cur_ram});
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    pulse_start(1'b0);
    wait_done(400, ok);
    total++;
    if (!ok || go_order.size() != 2 || ram_fail !== 8'h00 || timeout !== 1'b0)
      $display("[TB] FAIL reset_mid_rerun: got done=%b rises=%0d ram_fail=%h want 1/2/00",
               ok, go_order.size(), ram_fail);
    else passed++;
  endtask

  task automatic test_timeout;
    bit ok;
    set_models(4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    hang[0] = 1'b1;
    pulse_start(1'b0);
    wait_done(200, ok);
    total++;
    if (!ok || timeout !== 1'b1)
      $display("[TB] FAIL timeout_flag: got %b want 1", timeout);
    else passed++;
    total++;
    if (last_done_cyc - go_rise_cyc[0] != 51)
      $display("[TB] FAIL timeout_latency: got %0d want 51", last_done_cyc - go_rise_cyc[0]);
    else passed++;
    total++;
    if (bist_go !== 2'b01 || busy !== 1'b0)
      $display("[TB] FAIL timeout_hold: got go=%b busy=%b want 01/0", bist_go, busy);
    else passed++;
    pulse_start(1'b0);
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done_cnt != 0 || bist_go !== 2'b01 || timeout !== 1'b1)
      $display("[TB] FAIL timeout_start_ignored: got busy=%b dones=%0d go=%b want 0/0/01",
               busy, done_cnt, bist_go);
    else passed++;
  endtask

  initial begin
    go_p = 2'b00;
    chk_p = 2'b00;
    done_cnt = 0;
    last_done_cyc = 0;
    last_bdone_cyc = 0;
    go_rise_cyc[0] = 0;
    go_rise_cyc[1] = 0;
    test_reset;
    test_basic;
    test_march_fail;
    test_checks;
    test_chk_bad;
    test_reset_mid;
    test_timeout;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
